// File: rtl/weight_fetch_sched.sv
// Weight-fetch scheduler: shares one weight-memory read port among NUM_TILES
// inference tiles. Each tile pulses a layer-0 or layer-1 request; requests are
// latched, arbitrated round-robin (layer 1 first within a tile), and served as
// one burst of consecutive row reads. Returning rows are tagged with the
// destination tile, layer and row index, and the last row of a burst raises
// burst_done for that tile. Only one burst is ever in flight.
module weight_fetch_sched #(
  parameter int NUM_TILES   = 4,
  parameter int NUM_NEURONS = 128,
  parameter int IMG_SZ      = 784,
  parameter int OUTPUT_SZ   = 10,
  parameter int L1_BASE     = 1024,
  parameter int MEM_LAT     = 2,
  parameter int ADDR_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_TILES-1:0]         get_weights0,
  input  logic [NUM_TILES-1:0]         get_weights1,
  output logic                         mem_rd_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [NUM_NEURONS*32-1:0]    mem_rdata,
  output logic                         w_valid,
  output logic [$clog2(NUM_TILES)-1:0] w_dest,
  output logic                         w_layer,
  output logic [$clog2(IMG_SZ):0]      w_idx,
  output logic [NUM_NEURONS*32-1:0]    w_data,
  output logic [NUM_TILES-1:0]         burst_done,
  output logic                         busy
);

  localparam int DEST_W = $clog2(NUM_TILES);
  localparam int IDX_W  = $clog2(IMG_SZ) + 1;

  // Layer-1 rows carry only OUTPUT_SZ meaningful words and the return path
  // needs at least one pipeline stage; reject configurations that break this.
  if (OUTPUT_SZ > NUM_NEURONS || MEM_LAT < 1) begin : g_bad_params
    $error("weight_fetch_sched: OUTPUT_SZ must be <= NUM_NEURONS and MEM_LAT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  // Tag travelling alongside an outstanding read.
  typedef struct packed {
    logic              valid;
    logic              last;
    logic [DEST_W-1:0] dest;
    logic              layer;
    logic [IDX_W-1:0]  idx;
  } tag_t;

  state_t              cs;
  logic [NUM_TILES-1:0] pend0, pend1;
  logic [NUM_TILES-1:0] clr0, clr1;
  logic [DEST_W-1:0]   rr_ptr;
  logic [DEST_W-1:0]   grant_tile;
  logic                grant_layer;
  logic [IDX_W-1:0]    count;
  logic [IDX_W-1:0]    cnt;
  logic                issue_last;

  logic                any_pend;
  logic [DEST_W-1:0]   pick_tile;
  logic                pick_layer;

  tag_t                pipe [MEM_LAT];
  tag_t                ret;

  // Round-robin search from rr_ptr upward with wrap; layer 1 wins within a tile.
  always_comb begin
    int t;
    logic [DEST_W-1:0] tt;
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    t          = 0;
    tt         = '0;
    any_pend   = 1'b0;
    pick_tile  = '0;
    pick_layer = 1'b0;
    for (int i = 0; i < NUM_TILES; i++) begin
      t  = (int'(rr_ptr) + i) % NUM_TILES;
      tt = DEST_W'(t);
      if (!any_pend && (pend0[tt] || pend1[tt])) begin
        any_pend   = 1'b1;
        pick_tile  = tt;
        pick_layer = pend1[tt];
      end
    end
  end

  // Clear mask for the request bit consumed by a grant this cycle.
  always_comb begin
    clr0 = '0;
    clr1 = '0;
    if (cs == S_IDLE && any_pend) begin
      if (pick_layer) clr1[pick_tile] = 1'b1;
      else            clr0[pick_tile] = 1'b1;
    end
  end

  // Pending request bits: a new pulse beats a same-cycle grant clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend0 <= '0;
      pend1 <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      pend0 <= (pend0 & ~clr0) | get_weights0;
      pend1 <= (pend1 & ~clr1) | get_weights1;
    end
  end

  // Burst FSM: grant in S_IDLE, one row read per cycle in S_ISSUE,
  // wait for the final row in S_DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs          <= S_IDLE;
      rr_ptr      <= '0;
      grant_tile  <= '0;
      grant_layer <= 1'b0;
      count       <= '0;
      cnt         <= '0;
      issue_last  <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
    end else begin
      case (cs)
        S_IDLE: begin
          if (any_pend) begin
            grant_tile  <= pick_tile;
            grant_layer <= pick_layer;
            count       <= pick_layer ? IDX_W'(NUM_NEURONS) : IDX_W'(IMG_SZ);
            rr_ptr      <= (int'(pick_tile) == NUM_TILES - 1) ? '0
                                                              : pick_tile + DEST_W'(1);
            // First row is issued on entry to S_ISSUE.
            cnt         <= '0;
            issue_last  <= pick_layer ? (NUM_NEURONS == 1) : (IMG_SZ == 1);
            mem_rd_en   <= 1'b1;
            mem_addr    <= pick_layer ? ADDR_W'(L1_BASE) : '0;
            cs          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue_last) begin
            mem_rd_en <= 1'b0;
            cs        <= S_DRAIN;
          end else begin
            cnt        <= cnt + IDX_W'(1);
            mem_addr   <= mem_addr + ADDR_W'(1);
            issue_last <= (cnt + IDX_W'(2) == count);
          end
        end
        S_DRAIN: begin
          if (ret.valid && ret.last) cs <= S_IDLE;
        end
        default: cs <= S_IDLE;
      endcase
    end
  end

  // Return-path tag pipeline, aligned with mem_rdata MEM_LAT cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this tag array is cleared on reset because a stale valid bit
      // would otherwise deliver a row from an aborted burst.
      for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: mem_rd_en, last: issue_last, dest: grant_tile,
                   layer: grant_layer, idx: cnt};
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign ret     = pipe[MEM_LAT-1];
  assign w_valid = ret.valid;
  assign w_dest  = ret.dest;
  assign w_layer = ret.layer;
  assign w_idx   = ret.idx;
  assign w_data  = mem_rdata;
  assign busy    = (cs != S_IDLE) || (|pend0) || (|pend1);

  // One-cycle completion pulse to the tile receiving the last row.
  always_comb begin
    burst_done = '0;
    if (ret.valid && ret.last) burst_done[ret.dest] = 1'b1;
  end

endmodule

// File: tb/tb_weight_fetch_sched.sv
// Directed bench for weight_fetch_sched with a small configuration:
// IMG_SZ=4, NUM_NEURONS=3, MEM_LAT=2, NUM_TILES=4, L1_BASE=16.
module tb_weight_fetch_sched;

  localparam int NT  = 4;
  localparam int NN  = 3;
  localparam int IMG = 4;
  localparam int OSZ = 2;
  localparam int L1B = 16;
  localparam int LAT = 2;
  localparam int AW  = 16;
  localparam int DW  = NN * 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [NT-1:0] gw0, gw1;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          w_valid;
  logic [1:0]    w_dest;
  logic          w_layer;
  logic [2:0]    w_idx;
  logic [DW-1:0] w_data;
  logic [NT-1:0] burst_done;
  logic          busy;

  weight_fetch_sched #(
    .NUM_TILES(NT), .NUM_NEURONS(NN), .IMG_SZ(IMG), .OUTPUT_SZ(OSZ),
    .L1_BASE(L1B), .MEM_LAT(LAT), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .get_weights0(gw0), .get_weights1(gw1),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .w_valid(w_valid), .w_dest(w_dest), .w_layer(w_layer), .w_idx(w_idx),
    .w_data(w_data), .burst_done(burst_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Row contents are a function of the row address.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < NN; k++) r[k*32 +: 32] = {a, 16'(k) ^ 16'hC3A0};
    return r;
  endfunction

  // Memory model: data for the address issued two cycles earlier.
  logic [AW-1:0] rq0, rq1;
  always @(posedge clk) begin
    rq0 <= mem_addr;
    rq1 <= rq0;
  end
  assign mem_rdata = pat(rq1);

  // Event monitor.
  typedef struct {
    int tile;
    int layer;
    int cyc;
    bit ok;
  } done_t;

  done_t done_q[$];
  int    start_q[$];
  int    addr_q[$];
  int    wv_cnt = 0;
  int    cyc = 0;
  logic  prev_rd = 1'b0;

  function automatic done_t mk_done(input int t, input int l, input int c, input bit ok);
    done_t d;
    d.tile = t; d.layer = l; d.cyc = c; d.ok = ok;
    return d;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      prev_rd <= 1'b0;
    end else begin
      if (mem_rd_en) addr_q.push_back(int'(mem_addr));
      if (mem_rd_en && !prev_rd) start_q.push_back(cyc);
      if (w_valid) wv_cnt <= wv_cnt + 1;
      if (burst_done != '0)
        done_q.push_back(mk_done(int'(w_dest), int'(w_layer), cyc,
                                 w_valid && (burst_done == (4'b0001 << w_dest)) &&
                                 (int'(w_idx) == (w_layer ? NN - 1 : IMG - 1))));
      prev_rd <= mem_rd_en;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic clear_mon();
    done_q.delete();
    start_q.delete();
    addr_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    gw0 = '0;
    gw1 = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Drive request pulses for exactly one cycle.
  task automatic pulse(input logic [NT-1:0] g0, input logic [NT-1:0] g1);
    gw0 = g0;
    gw1 = g1;
    @(posedge clk);
    #1;
    gw0 = '0;
    gw1 = '0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < limit);
    check({name, ".idle"}, busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd(input string name, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_rd_en && n < limit);
    check({name, ".rd_seen"}, mem_rd_en, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int k, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_q.size() < k && n < limit);
    check({name, ".done_seen"}, done_q.size() >= k, 1'b1);
  endtask

  int exp_t[$];
  int exp_l[$];
  int exp_a[$];

  task automatic check_bursts(input string name);
    check({name, ".n_bursts"}, done_q.size(), exp_t.size());
    for (int i = 0; i < exp_t.size() && i < done_q.size(); i++) begin
      check($sformatf("%s.b%0d.tile", name, i), done_q[i].tile, exp_t[i]);
      check($sformatf("%s.b%0d.layer", name, i), done_q[i].layer, exp_l[i]);
      check($sformatf("%s.b%0d.done_ok", name, i), done_q[i].ok, 1'b1);
    end
  endtask

  // Per-cycle vector for the single-request burst.
  typedef struct {
    logic [NT-1:0] gw0;
    logic          rd;
    int            addr;
    logic          wv;
    int            dest;
    logic          layer;
    int            idx;
    logic [NT-1:0] bd;
    logic          busy;
  } vec_t;

  function automatic vec_t mk(input logic [NT-1:0] g, input logic rd, input int addr,
                              input logic wv, input int dest, input logic layer,
                              input int idx, input logic [NT-1:0] bd, input logic bz);
    vec_t v;
    v.gw0 = g; v.rd = rd; v.addr = addr; v.wv = wv; v.dest = dest;
    v.layer = layer; v.idx = idx; v.bd = bd; v.busy = bz;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int diff;
    int wv_base;
    int rowaddr;

    // cycle:        gw0    rd addr wv dst lyr idx bd      busy
    vecs[0] = mk(4'b0100, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    vecs[1] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 1);
    vecs[2] = mk(4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 1);
    vecs[3] = mk(4'b0000, 1, 1, 0, 0, 0, 0, 4'b0000, 1);
    vecs[4] = mk(4'b0000, 1, 2, 1, 2, 0, 0, 4'b0000, 1);
    vecs[5] = mk(4'b0000, 1, 3, 1, 2, 0, 1, 4'b0000, 1);
    vecs[6] = mk(4'b0000, 0, 0, 1, 2, 0, 2, 4'b0000, 1);
    vecs[7] = mk(4'b0000, 0, 0, 1, 2, 0, 3, 4'b0100, 1);
    vecs[8] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    vecs[9] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 0);

    // Reset state.
    rst = 1'b1;
    gw0 = '0;
    gw1 = '0;
    #2;
    check("reset.rd_en", mem_rd_en, 1'b0);
    check("reset.addr", mem_addr, 0);
    check("reset.w_valid", w_valid, 1'b0);
    check("reset.w_dest", w_dest, 0);
    check("reset.w_idx", w_idx, 0);
    check("reset.burst_done", burst_done, 0);
    check("reset.busy", busy, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single layer-0 request from tile 2, checked cycle by cycle.
    for (int i = 0; i < 10; i++) begin
      gw0 = vecs[i].gw0;
      gw1 = '0;
      @(negedge clk);
      check($sformatf("single.c%0d.rd_en", i), mem_rd_en, vecs[i].rd);
      if (vecs[i].rd) check($sformatf("single.c%0d.addr", i), mem_addr, vecs[i].addr);
      check($sformatf("single.c%0d.w_valid", i), w_valid, vecs[i].wv);
      if (vecs[i].wv) begin
        rowaddr = vecs[i].layer ? L1B + vecs[i].idx : vecs[i].idx;
        check($sformatf("single.c%0d.w_dest", i), w_dest, vecs[i].dest);
        check($sformatf("single.c%0d.w_layer", i), w_layer, vecs[i].layer);
        check($sformatf("single.c%0d.w_idx", i), w_idx, vecs[i].idx);
        check($sformatf("single.c%0d.w_data", i), w_data, pat(AW'(rowaddr)));
      end
      check($sformatf("single.c%0d.burst_done", i), burst_done, vecs[i].bd);
      check($sformatf("single.c%0d.busy", i), busy, vecs[i].busy);
      @(posedge clk);
      #1;
    end

    // Round-robin over tiles 0,1,3; tile 0 re-requests while tile 3 runs.
    do_reset();
    clear_mon();
    pulse(4'b1011, 4'b0000);
    wait_done("rr", 2, 100);
    wait_rd("rr", 50);
    pulse(4'b0001, 4'b0000);
    wait_idle("rr", 200);
    exp_t = '{0, 1, 3, 0};
    exp_l = '{0, 0, 0, 0};
    check_bursts("rr");
    check("rr.n_reads", addr_q.size(), 16);

    // Layer priority within tile 1 and duplicate-request merge.
    do_reset();
    clear_mon();
    pulse(4'b0001, 4'b0000);
    wait_rd("prio", 20);
    pulse(4'b0010, 4'b0000);
    pulse(4'b0000, 4'b0010);
    pulse(4'b0010, 4'b0000);
    wait_idle("prio", 200);
    exp_t = '{0, 1, 1};
    exp_l = '{0, 1, 0};
    check_bursts("prio");
    exp_a = '{0, 1, 2, 3, 16, 17, 18, 0, 1, 2, 3};
    check("prio.n_reads", addr_q.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < addr_q.size(); i++)
      check($sformatf("prio.addr%0d", i), addr_q[i], exp_a[i]);

    // New request for tile 0 in the very cycle its pending bit is granted.
    do_reset();
    clear_mon();
    pulse(4'b0001, 4'b0000);
    pulse(4'b0001, 4'b0000);
    wait_idle("coll", 200);
    exp_t = '{0, 0};
    exp_l = '{0, 0};
    check_bursts("coll");
    check("coll.n_starts", start_q.size(), 2);
    if (start_q.size() >= 2 && done_q.size() >= 1) begin
      diff = start_q[1] - done_q[0].cyc;
      check("coll.gap", diff <= 2, 1'b1);
    end

    // Reset during the second issue cycle aborts everything.
    do_reset();
    clear_mon();
    pulse(4'b0100, 4'b1000);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    check("rstmid.pre_rd_en", mem_rd_en, 1'b1);
    rst = 1'b1;
    #1;
    check("rstmid.rd_en", mem_rd_en, 1'b0);
    check("rstmid.addr", mem_addr, 0);
    check("rstmid.w_valid", w_valid, 1'b0);
    check("rstmid.burst_done", burst_done, 0);
    check("rstmid.busy", busy, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
    wv_base = wv_cnt;
    repeat (12) @(posedge clk);
    #1;
    check("rstmid.no_w_valid", wv_cnt - wv_base, 0);
    check("rstmid.no_reads", addr_q.size(), 0);
    check("rstmid.no_done", done_q.size(), 0);
    check("rstmid.busy_after", busy, 1'b0);

    // Saturation: every tile requests both layers at once.
    do_reset();
    clear_mon();
    pulse(4'b1111, 4'b1111);
    wait_idle("sat", 400);
    exp_t = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_l = '{1, 1, 1, 1, 0, 0, 0, 0};
    check_bursts("sat");
    check("sat.n_starts", start_q.size(), 8);
    check("sat.n_reads", addr_q.size(), 4 * NN + 4 * IMG);
    for (int k = 0; k + 1 < start_q.size() && k < done_q.size(); k++) begin
      diff = start_q[k+1] - done_q[k].cyc;
      check($sformatf("sat.gap%0d", k), diff <= 2, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
